// File: rtl/mips_boot_ctrl.sv
`default_nettype none
//============================================================================
// Module : mips_boot_ctrl
// Streams boot images into i/d memory, then runs the core and captures debug.
// Rev    : 1.0
//============================================================================
module mips_boot_ctrl #(
    parameter int DATA_W      = 32,
    parameter int IADDR_W     = 4,
    parameter int DADDR_W     = 5,
    parameter int CYC_W       = 16,
    parameter int RUN_CYCLES  = 500,
    parameter int RELEASE_DLY = 2,
    parameter int SEL_W       = 5,
    parameter int DBG_SEL     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IADDR_W:0]   imem_words,
    input  logic [DADDR_W:0]   dmem_words,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [DATA_W-1:0]  ld_data,
    output logic               imem_we,
    output logic [IADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0]  imem_wdata,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic               core_rst,
    output logic [SEL_W-1:0]   dbg_sel,
    input  logic [DATA_W-1:0]  debug_data,
    input  logic               core_halt,
    output logic               busy,
    output logic               done,
    output logic               halted,
    output logic [DATA_W-1:0]  result
);

    localparam int IDX_W  = ((IADDR_W > DADDR_W) ? IADDR_W : DADDR_W) + 1;
    localparam int IDEPTH = 1 << IADDR_W;
    localparam int DDEPTH = 1 << DADDR_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_I  = 3'd1,
        S_LOAD_D  = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   icnt_q, icnt_d;
    logic [IDX_W-1:0]   dcnt_q, dcnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CYC_W-1:0]   cnt_q, cnt_d;
    logic               imem_we_q, imem_we_d;
    logic [IADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0]  imem_wdata_q, imem_wdata_d;
    logic               dmem_we_q, dmem_we_d;
    logic [DADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0]  dmem_wdata_q, dmem_wdata_d;
    logic               core_rst_q, core_rst_d;
    logic               halted_q, halted_d;
    logic [DATA_W-1:0]  result_q, result_d;

    logic [IDX_W-1:0]   w_icnt;
    logic [IDX_W-1:0]   w_dcnt;
    logic               w_accept;
    logic               w_run_end;

    assign w_icnt = (int'(imem_words) > IDEPTH) ? IDX_W'(IDEPTH) : IDX_W'(imem_words);
    assign w_dcnt = (int'(dmem_words) > DDEPTH) ? IDX_W'(DDEPTH) : IDX_W'(dmem_words);

    assign ld_ready  = (state_q == S_LOAD_I) || (state_q == S_LOAD_D);
    assign w_accept  = ld_valid && ld_ready;
    // A simultaneous halt and limit reports as a halt because halted takes core_halt directly.
    assign w_run_end = core_halt ||
                       ((RUN_CYCLES != 0) && (cnt_q == CYC_W'(RUN_CYCLES - 1)));

    always_comb begin
        state_d      = state_q;
        icnt_d       = icnt_q;
        dcnt_d       = dcnt_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        dmem_we_d    = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        core_rst_d   = core_rst_q;
        halted_d     = halted_q;
        result_d     = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    icnt_d     = w_icnt;
                    dcnt_d     = w_dcnt;
                    idx_d      = '0;
                    cnt_d      = '0;
                    halted_d   = 1'b0;
                    result_d   = '0;
                    core_rst_d = 1'b0;
                    if (w_icnt != '0)      state_d = S_LOAD_I;
                    else if (w_dcnt != '0) state_d = S_LOAD_D;
                    else                   state_d = S_RELEASE;
                end
            end
            S_LOAD_I: begin
                if (w_accept) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = idx_q[IADDR_W-1:0];
                    imem_wdata_d = ld_data;
                    if (idx_q == icnt_q - IDX_W'(1)) begin
                        idx_d   = '0;
                        state_d = (dcnt_q != '0) ? S_LOAD_D : S_RELEASE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_LOAD_D: begin
                if (w_accept) begin
                    dmem_we_d    = 1'b1;
                    dmem_addr_d  = idx_q[DADDR_W-1:0];
                    dmem_wdata_d = ld_data;
                    if (idx_q == dcnt_q - IDX_W'(1)) begin
                        idx_d   = '0;
                        state_d = S_RELEASE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_RELEASE: begin
                // The first RELEASE cycle coincides with the final write strobe.
                if (cnt_q >= CYC_W'(RELEASE_DLY - 1)) begin
                    state_d    = S_RUN;
                    core_rst_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CYC_W'(1);
                end
            end
            S_RUN: begin
                if (w_run_end) begin
                    state_d    = S_DONE;
                    core_rst_d = 1'b0;
                    halted_d   = core_halt;
                    result_d   = debug_data;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CYC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            icnt_q       <= '0;
            dcnt_q       <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            core_rst_q   <= 1'b0;
            halted_q     <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            icnt_q       <= icnt_d;
            dcnt_q       <= dcnt_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            core_rst_q   <= core_rst_d;
            halted_q     <= halted_d;
            result_q     <= result_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign core_rst   = core_rst_q;
    assign dbg_sel    = SEL_W'(DBG_SEL);
    assign busy       = (state_q == S_LOAD_I) || (state_q == S_LOAD_D) ||
                        (state_q == S_RELEASE) || (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign halted     = halted_q;
    assign result     = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_boot_ctrl.sv
`default_nettype none
//============================================================================
// Module : tb_mips_boot_ctrl
// Scoreboard bench: driver queues expected writes/run outcomes, monitor checks.
// Rev    : 1.0
//============================================================================
module tb_mips_boot_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  imem_words;
    logic [5:0]  dmem_words;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        dmem_we;
    logic [4:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic        core_rst;
    logic [4:0]  dbg_sel;
    logic [31:0] debug_data;
    logic        core_halt;
    logic        busy;
    logic        done;
    logic        halted;
    logic [31:0] result;

    typedef struct {
        logic        halted;
        logic [31:0] result;
        int          cycles;
    } run_exp_t;

    logic [63:0] iq[$];
    logic [63:0] dq[$];
    run_exp_t    rq[$];

    int tests = 0;
    int fails = 0;

    mips_boot_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_words(imem_words), .dmem_words(dmem_words),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .core_rst(core_rst), .dbg_sel(dbg_sel), .debug_data(debug_data),
        .core_halt(core_halt), .busy(busy), .done(done), .halted(halted),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or finishes a run.
    int  mcyc = 0;
    int  last_wr = 0;
    bit  wrote = 0;
    int  run_cnt = 0;
    logic core_rst_prev = 1'b0;
    logic done_prev = 1'b0;

    always @(negedge clk) begin
        mcyc++;
        if (!rst) begin
            run_cnt = 0;
            wrote = 0;
            core_rst_prev = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (imem_we) begin
                if (iq.size() == 0) chk("imem_unexpected", {32'(imem_addr), imem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("imem_write", {32'(imem_addr), imem_wdata}, iq.pop_front());
                last_wr = mcyc;
                wrote = 1;
            end
            if (dmem_we) begin
                if (dq.size() == 0) chk("dmem_unexpected", {32'(dmem_addr), dmem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("dmem_write", {32'(dmem_addr), dmem_wdata}, dq.pop_front());
                last_wr = mcyc;
                wrote = 1;
            end
            if (core_rst && !core_rst_prev && wrote) begin
                chk("release_gap", 128'(mcyc - last_wr), 128'd2);
                wrote = 0;
            end
            if (core_rst) run_cnt++;
            if (done && !done_prev) begin
                if (rq.size() == 0) begin
                    chk("done_unexpected", 128'(done), 128'd0);
                end else begin
                    run_exp_t e;
                    e = rq.pop_front();
                    chk("run_outcome", {31'd0, halted, result, 32'(run_cnt)},
                        {31'd0, e.halted, e.result, 32'(e.cycles)});
                end
                run_cnt = 0;
            end
            core_rst_prev = core_rst;
            done_prev = done;
        end
    end

    task automatic do_start(input int iw, input int dw);
        @(posedge clk); #1;
        imem_words = 5'(iw);
        dmem_words = 6'(dw);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Words 0..exp_i-1 go to imem, the rest to dmem, addresses from 0 in each.
    task automatic load_words(input int n, input int exp_i, input bit gaps, input logic [31:0] base);
        int budget;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                ld_valid = 1'b0;
                @(posedge clk); #1;
            end
            ld_valid = 1'b1;
            ld_data  = base + 32'(k);
            budget   = 0;
            forever begin
                @(negedge clk);
                if (ld_ready) begin
                    if (k < exp_i) iq.push_back({32'(k), ld_data});
                    else           dq.push_back({32'(k - exp_i), ld_data});
                    @(posedge clk); #1;
                    break;
                end
                budget++;
                if (budget > 50) begin
                    chk("ld_ready_timeout", 128'd0, 128'd1);
                    break;
                end
                @(posedge clk); #1;
            end
        end
        ld_valid = 1'b0;
    endtask

    // n_halt < 0: run to the cycle limit (with a stray start mid-run that must be ignored).
    task automatic run_case(input int n_halt, input logic [31:0] val, input logic exp_h, input int exp_cyc);
        int budget;
        int rdy_bad;
        run_exp_t e;
        e.halted = exp_h;
        e.result = val;
        e.cycles = exp_cyc;
        rq.push_back(e);
        debug_data = (n_halt < 0) ? val : 32'h0BAD_0000;
        budget = 0;
        rdy_bad = 0;
        forever begin
            @(negedge clk);
            if (ld_ready) rdy_bad++;
            if (core_rst) break;
            budget++;
            if (budget > 50) begin
                chk("core_rst_timeout", 128'd0, 128'd1);
                break;
            end
        end
        chk("release_ready_low", 128'(rdy_bad), 128'd0);
        if (n_halt >= 0) begin
            repeat (n_halt) @(posedge clk);
            #1;
            core_halt  = 1'b1;
            debug_data = val;
            @(posedge clk); #1;
            core_halt  = 1'b0;
            debug_data = 32'hDEAD_BEEF;
        end else begin
            repeat (100) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        budget = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            budget++;
            if (budget > 1000) begin
                chk("done_timeout", 128'd0, 128'd1);
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        start = 1'b0;
        imem_words = '0;
        dmem_words = '0;
        ld_valid = 1'b0;
        ld_data = '0;
        debug_data = '0;
        core_halt = 1'b0;
        #12;
        chk("rst_outputs", {ld_ready, imem_we, dmem_we, core_rst, busy, done, halted},
            7'b0);
        chk("rst_result", 128'(result), 128'd0);
        chk("rst_dbg_sel", 128'(dbg_sel), 128'd8);
        @(posedge clk); #1;
        rst = 1'b1;

        // Full-depth back-to-back load, then run to the cycle limit.
        do_start(16, 20);
        chk("busy_after_start", 128'(busy), 128'd1);
        load_words(36, 16, 1'b0, 32'h1000_0000);
        run_case(-1, 32'hCAFE_0008, 1'b0, 500);

        // Restart from DONE clears status; gapped load; halt on run cycle 37.
        do_start(4, 3);
        chk("restart_clears", {done, halted, result}, 34'd0);
        load_words(7, 4, 1'b1, 32'h2000_0000);
        run_case(37, 32'h3700_00AA, 1'b1, 38);

        // Halt coincides with the cycle limit.
        do_start(2, 2);
        chk("restart_clears_halt", {done, halted, result}, 34'd0);
        load_words(4, 2, 1'b0, 32'h3000_0000);
        run_case(499, 32'h4990_0001, 1'b1, 500);

        // Nothing to load.
        do_start(0, 0);
        run_case(3, 32'h0000_0003, 1'b1, 4);

        // Oversized imem count clamps to 16.
        do_start(31, 0);
        load_words(16, 16, 1'b0, 32'h5000_0000);
        run_case(5, 32'h5555_0005, 1'b1, 6);

        // Asynchronous reset in the middle of LOAD_D.
        do_start(3, 5);
        load_words(5, 3, 1'b0, 32'h6000_0000);
        @(posedge clk); #4;
        rst = 1'b0;
        #1;
        chk("rst_mid_load", {ld_ready, busy, dmem_we, core_rst}, 4'b0);
        chk("rst_mid_load_addr", {dmem_addr, dmem_wdata}, 37'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        do_start(2, 3);
        load_words(5, 2, 1'b0, 32'h7000_0000);
        run_case(10, 32'hAAAA_0010, 1'b1, 11);

        // Asynchronous reset in the middle of RUN.
        do_start(1, 0);
        load_words(1, 1, 1'b0, 32'h8000_0000);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (core_rst) break;
        end
        chk("run_started", 128'(core_rst), 128'd1);
        repeat (20) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_mid_run", {core_rst, busy, done, halted}, 4'b0);
        chk("rst_mid_run_result", 128'(result), 128'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        do_start(1, 1);
        load_words(2, 1, 1'b0, 32'h9000_0000);
        run_case(2, 32'h9999_0002, 1'b1, 3);

        repeat (3) @(posedge clk);
        chk("queues_drained", 128'(iq.size() + dq.size() + rq.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_boot_ctrl.md
Name: mips_boot_ctrl

Overview:
- Hardware replacement for the bench-side memory preload and fixed-length run of the MIPS top.
- Holds the core in reset and streams words from a valid/ready load port into instruction memory, then data memory.
- Releases the core after a programmable delay, runs it for a bounded cycle count or until halt, then captures the debug word and freezes the core.
- Sits between the host/loader interface and the mips core plus its i/d memories.

Parameters:
DATA_W, 32, memory word and debug data width
IADDR_W, 4, instruction memory address width (depth 2^IADDR_W)
DADDR_W, 5, data memory address width (depth 2^DADDR_W)
CYC_W, 16, run cycle counter width
RUN_CYCLES, 500, run length in cycles; 0 = unlimited (halt only)
RELEASE_DLY, 2, cycles core reset is held after last write (minimum 1)
SEL_W, 5, debug select width
DBG_SEL, 8, debug select value driven to core

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse; honoured only in IDLE or DONE
imem_words  in  IADDR_W+1  number of instruction words to load
dmem_words  in  DADDR_W+1  number of data words to load
ld_valid  in  1  load word valid
ld_ready  out  1  load word accepted when ld_valid & ld_ready
ld_data  in  DATA_W  load word
imem_we  out  1  instruction memory write strobe
imem_addr  out  IADDR_W  instruction memory write address
imem_wdata  out  DATA_W  instruction memory write data
dmem_we  out  1  data memory write strobe
dmem_addr  out  DADDR_W  data memory write address
dmem_wdata  out  DATA_W  data memory write data
core_rst  out  1  active-low reset to core
dbg_sel  out  SEL_W  constant DBG_SEL
debug_data  in  DATA_W  core debug output
core_halt  in  1  core halt indication
busy  out  1  high in LOAD_I, LOAD_D, RELEASE, RUN
done  out  1  high in DONE
halted  out  1  in DONE: run ended by core_halt (0 = cycle limit)
result  out  DATA_W  debug_data captured at end of run

Behaviour:
- Reset (asynchronous, rst=0):
  - State goes to IDLE immediately; counters clear.
  - core_rst=0, ld_ready=0, all write strobes/addresses/data=0.
  - busy=done=halted=0, result=0.
  - Applies equally mid-load or mid-run.
- States: IDLE, LOAD_I, LOAD_D, RELEASE, RUN, DONE.
- IDLE/DONE + start:
  - Latch imem_words and dmem_words, clamped to 2^IADDR_W and 2^DADDR_W respectively.
  - Go to LOAD_I if imem count >0, else LOAD_D if dmem count >0, else RELEASE.
  - Entering from DONE clears done, halted and result; core_rst is already 0.
- LOAD_I:
  - ld_ready=1.
  - Each accepted word is written one cycle later: imem_we=1, imem_addr=index (from 0), imem_wdata=word.
  - Gaps in ld_valid stall without writes.
  - Accepting word count-1 moves to LOAD_D (or RELEASE if dmem count =0); ld_ready drops that next cycle.
- LOAD_D: identical on the dmem port.
  - An accept on the LOAD_I→LOAD_D boundary cycle never occurs, because ld_ready is evaluated per state.
- ld_valid is ignored whenever ld_ready=0; no write occurs.
- RELEASE:
  - core_rst stays 0 for RELEASE_DLY cycles after the final write strobe.
  - Then core_rst=1 and the state enters RUN.
- RUN:
  - Cycle counter starts at 0 on the first cycle with core_rst=1 and increments every cycle.
  - Ends on core_halt=1 (halted=1) or counter == RUN_CYCLES-1 (halted=0), whichever comes first.
  - If both occur in the same cycle, halted=1.
  - If RUN_CYCLES=0, the run ends only on core_halt; the counter saturates and does not wrap.
  - On the ending cycle, debug_data is registered into result. Next cycle: state=DONE, core_rst=0, done=1.
- start is ignored in LOAD_I, LOAD_D, RELEASE and RUN.
- dbg_sel is constant DBG_SEL, including during reset.

Test Plan:
- Reset, start with imem_words=16, dmem_words=20, 36 back-to-back words → imem_we at addresses 0..15, then dmem_we at 0..19, each one cycle after accept; core_rst rises exactly 2 cycles after the last write.
- Toggle ld_valid every other cycle during load → writes only on accepted words, addresses contiguous, no duplicates.
- RUN_CYCLES=500, core_halt tied 0, debug_data=32'hCAFE0008 → core_rst high for exactly 500 cycles; done=1, halted=0, result=32'hCAFE0008.
- Assert core_halt on run cycle 37 → DONE next cycle with halted=1 and result sampled on that cycle; test again with halt on cycle 499, where halt and limit coincide → halted=1.
- Start with imem_words=0, dmem_words=0 → no writes, ld_ready stays 0, straight to RELEASE/RUN; start with imem_words=31 → clamped to 16 writes.
- Drop rst mid-LOAD_D and mid-RUN → outputs return to reset values immediately without a clock edge; a subsequent start reloads from address 0.
